perm_rotq_pipe: RTL and testbench

PERM_ROTQ_PIPE -- requirements
Module: perm_rotq_pipe

---
 rtl/perm_rotq_pipe.sv | 177 +++++++++++++++++
 tb/tb_perm_rotq_pipe.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perm_rotq_pipe.sv
// perm_rotq_pipe: byte/bit rotate, shift and rotate-and-mask permute unit.
// Latency: STAGES cycles from acceptance to out_valid. Full throughput, no bubbles.
// Backpressure: out_ready low stalls the last stage. Upstream stages keep filling empty slots,
//   so in_ready drops only when every stage holds data and the last stage cannot drain.
//
// Optional feature: define PERM_ROTQ_OPCOUNT_EN to add the op_count output.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   in_valid / in_ready   operation handshake (op, ra, cnt, tag_in)
//   op [2:0]              000 rotl bytes, 001 rotl bits, 010 shl bytes, 011 shl bits,
//                         100 rotate-and-mask right bytes, 101..111 reserved
//   ra [0:DATA_W-1]       operand, bit 0 is the MSB
//   cnt [0:6]             count, bit 6 is the LSB
//   flush                 kills every in-flight operation
//   out_valid / out_ready result handshake (result, tag_out, illegal)
//   op_count [15:0]       accepted non-reserved operations (optional)
module perm_rotq_pipe #(
    parameter int DATA_W = 128,
    parameter int STAGES = 2,
    parameter int TAG_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [0:DATA_W-1] ra,
    input  logic [0:6]        cnt,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:DATA_W-1] result,
    output logic [TAG_W-1:0]  tag_out,
    output logic              illegal
`ifdef PERM_ROTQ_OPCOUNT_EN
    ,
    output logic [15:0]       op_count
`endif
);

    localparam int NB = DATA_W / 8;

    // ------------------------------------------------------------------
    // Permute datapath (combinational, feeds the first stage)
    // ------------------------------------------------------------------

    // Numeric view of the operand: MSB-first port bit 0 lands on opnd[DATA_W-1],
    // so "left" and "byte 0" line up with the usual shift operators.
    logic [DATA_W-1:0]   opnd;
    logic [3:0]          rb_s;      // byte rotate amount, reduced mod NB
    logic [2:0]          bit_s;     // bit rotate/shift amount
    logic [4:0]          sl_s;      // byte shift-left amount
    logic [4:0]          sr_s;      // byte shift-right amount for rotate-and-mask
    logic [2*DATA_W-1:0] rot_byte_w;
    logic [2*DATA_W-1:0] rot_bit_w;
    logic [DATA_W-1:0]   shl_byte;
    logic [DATA_W-1:0]   shl_bit;
    logic [DATA_W-1:0]   shr_byte;
    logic [DATA_W-1:0]   perm;
    logic                perm_ill;

    assign opnd  = ra;
    // NB is a power of two (8 or 16), so the modulo is a mask.
    assign rb_s  = cnt[3:6] & 4'(NB - 1);
    assign bit_s = cnt[4:6];
    assign sl_s  = cnt[2:6];
    // Rotate-and-mask encodes a right shift as the negated left count.
    assign sr_s  = 5'd0 - cnt[2:6];

    // Rotates: shift a doubled copy and keep the upper half.
    assign rot_byte_w = {opnd, opnd} << {rb_s, 3'b000};
    assign rot_bit_w  = {opnd, opnd} << bit_s;
    // Shift amounts of NB bytes or more shift everything out, giving zero.
    assign shl_byte   = opnd << {sl_s, 3'b000};
    assign shl_bit    = opnd << bit_s;
    assign shr_byte   = opnd >> {sr_s, 3'b000};

    always_comb begin
        perm     = '0;
        perm_ill = 1'b0;
        case (op)
            3'b000:  perm = rot_byte_w[2*DATA_W-1 -: DATA_W];
            3'b001:  perm = rot_bit_w[2*DATA_W-1 -: DATA_W];
            3'b010:  perm = shl_byte;
            3'b011:  perm = shl_bit;
            3'b100:  perm = shr_byte;
            default: perm_ill = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic              accept;

    logic [DATA_W-1:0] st_dat [STAGES];
    logic [TAG_W-1:0]  st_tag [STAGES];
    logic [STAGES-1:0] st_ill;

    // A stage advances when it, or any stage downstream of it, is empty, or
    // when the output is being taken. Built as a running OR from the tail so
    // the chain has no combinational self-reference.
    always_comb begin
        logic chain;
        chain = out_ready;
        adv   = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain  = chain | ~vld[k];
            adv[k] = chain;
        end
    end

    // Flush and reset refuse new work in the same cycle.
    assign in_ready = adv[0] & ~flush & ~reset;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld    <= '0;
            st_ill <= '0;
            for (int k = 0; k < STAGES; k++) begin
                st_dat[k] <= '0;
                st_tag[k] <= '0;
            end
        end else if (flush) begin
            // Data registers keep their contents; only occupancy is dropped.
            vld <= '0;
        end else begin
            if (adv[0]) begin
                vld[0] <= accept;
                if (accept) begin
                    st_dat[0] <= perm;
                    st_tag[0] <= tag_in;
                    st_ill[0] <= perm_ill;
                end
            end
            // Later stages only move data; payload registers load only when
            // real data arrives so the output holds its last value otherwise.
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        st_dat[k] <= st_dat[k-1];
                        st_tag[k] <= st_tag[k-1];
                        st_ill[k] <= st_ill[k-1];
                    end
                end
            end
        end
    end

    assign out_valid = vld[STAGES-1];
    assign result    = st_dat[STAGES-1];
    assign tag_out   = st_tag[STAGES-1];
    assign illegal   = st_ill[STAGES-1];

`ifdef PERM_ROTQ_OPCOUNT_EN
    // Counts accepted non-reserved ops; survives flush, wraps naturally.
    logic [15:0] op_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            op_cnt_q <= '0;
        end else if (accept && (op < 3'd5)) begin
            op_cnt_q <= op_cnt_q + 16'd1;
        end
    end

    assign op_count = op_cnt_q;
`endif

endmodule

// File: tb/tb_perm_rotq_pipe.sv
// tb_perm_rotq_pipe: self-checking bench for perm_rotq_pipe (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are checked 4 units
// after it; the scoreboard monitor samples handshakes on the falling edge.
module tb_perm_rotq_pipe;

    localparam int DATA_W = 128;
    localparam int STAGES = 2;
    localparam int TAG_W  = 7;

    localparam logic [127:0] SEQ   = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] EXP27 = 128'h030405060708090A0B0C0D0E0F000102;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op;
    logic [0:DATA_W-1] ra;
    logic [0:6]        cnt;
    logic [TAG_W-1:0]  tag_in;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [0:DATA_W-1] result;
    logic [TAG_W-1:0]  tag_out;
    logic              illegal;
`ifdef PERM_ROTQ_OPCOUNT_EN
    logic [15:0]       op_count;
`endif

    always #5 clk = ~clk;

    perm_rotq_pipe #(.DATA_W(DATA_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .ra(ra), .cnt(cnt), .tag_in(tag_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .tag_out(tag_out), .illegal(illegal)
`ifdef PERM_ROTQ_OPCOUNT_EN
        , .op_count(op_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [127:0] res;
        logic [6:0]   tag;
        logic         ill;
    } exp_t;

    exp_t sb[$];

    // Reference model built on a byte array, indexed from the MSB end.
    function automatic exp_t model(input logic [2:0] o, input logic [127:0] a,
                                   input logic [6:0] c, input logic [6:0] t);
        logic [7:0] b [16];
        logic [7:0] r [16];
        int         s;
        exp_t       e;
        for (int i = 0; i < 16; i++) begin
            b[i] = a[127-8*i -: 8];
            r[i] = 8'h00;
        end
        e.tag = t;
        e.ill = 1'b0;
        e.res = '0;
        case (o)
            3'd0: begin
                s = int'(c[3:0]) % 16;
                for (int i = 0; i < 16; i++) r[i] = b[(i + s) % 16];
            end
            3'd2: begin
                s = int'(c[4:0]);
                for (int i = 0; i < 16; i++) if (i + s < 16) r[i] = b[i + s];
            end
            3'd4: begin
                s = (32 - int'(c[4:0])) % 32;
                for (int i = 0; i < 16; i++) if (i >= s) r[i] = b[i - s];
            end
            3'd1, 3'd3: ;
            default: e.ill = 1'b1;
        endcase
        for (int i = 0; i < 16; i++) e.res[127-8*i -: 8] = r[i];
        if (o == 3'd1) begin
            s = int'(c[2:0]);
            e.res = (s == 0) ? a : ((a << s) | (a >> (128 - s)));
        end else if (o == 3'd3) begin
            e.res = a << c[2:0];
        end
        return e;
    endfunction

    // Scoreboard monitor: push on acceptance, pop and compare on delivery.
    always @(negedge clk) begin
        exp_t e;
        if (reset || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got result=%h tag=%h ill=%b, required no output",
                             result, tag_out, illegal);
                end else begin
                    e = sb.pop_front();
                    if ({result, tag_out, illegal} !== {e.res, e.tag, e.ill}) begin
                        bad++;
                        $display("FAIL sb_result: got result=%h tag=%h ill=%b, required result=%h tag=%h ill=%b",
                                 result, tag_out, illegal, e.res, e.tag, e.ill);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(op, ra, cnt, tag_in));
        end
    end

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; ra = '0; cnt = '0; tag_in = '0;
        repeat (2) @(posedge clk);
        #4;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        total++; if (result !== '0) begin bad++; $display("FAIL rst_result: got %h, required 0", result); end
        total++; if (tag_out !== '0) begin bad++; $display("FAIL rst_tag: got %h, required 0", tag_out); end
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL rst_illegal: got %b, required 0", illegal); end
        @(posedge clk); #1;
        reset = 1'b0;
        #3;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready_after: got %b, required 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        op = 3'd0; ra = SEQ; cnt = 7'd3; tag_in = 7'd5; out_ready = 1'b1; in_valid = 1'b1;
        #3;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lat_accept: got in_ready=%b, required 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        #3;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early: got out_valid=%b, required 0", out_valid); end
        @(posedge clk); #4;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid: got out_valid=%b, required 1", out_valid); end
        total++; if (result !== EXP27) begin bad++; $display("FAIL lat_result: got %h, required %h", result, EXP27); end
        total++; if (tag_out !== 7'd5) begin bad++; $display("FAIL lat_tag: got %h, required 05", tag_out); end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [2:0]   o;
        logic [6:0]   c;
        logic [127:0] a;
        logic [127:0] e;
    } vec_t;

    task automatic test_ops();
        vec_t tbl [8];
        int   n;
        tbl[0] = '{3'd2, 7'd20,  SEQ, 128'h0};
        tbl[1] = '{3'd3, 7'd1,   128'h80000000000000000000000000000001, 128'h2};
        tbl[2] = '{3'd4, 7'h7E,  SEQ, 128'h0000000102030405060708090A0B0C0D};
        tbl[3] = '{3'd1, 7'd4,   SEQ, 128'h00102030405060708090A0B0C0D0E0F0};
        tbl[4] = '{3'd0, 7'd0,   128'hDEADBEEF0123456789ABCDEFFEDCBA98, 128'hDEADBEEF0123456789ABCDEFFEDCBA98};
        tbl[5] = '{3'd2, 7'd15,  SEQ, 128'h0F000000000000000000000000000000};
        tbl[6] = '{3'd0, 7'h13,  SEQ, EXP27};
        tbl[7] = '{3'd4, 7'h10,  SEQ, 128'h0};
        out_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            op = tbl[v].o; cnt = tbl[v].c; ra = tbl[v].a; tag_in = 7'(v + 16);
            in_valid = 1'b1;
            #3;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ops_accept[%0d]: got in_ready=%b, required 1", v, in_ready); end
            @(posedge clk); #1;
            in_valid = 1'b0;
            n = 0;
            while (n < 10) begin
                #3;
                if (out_valid) break;
                @(posedge clk); #1;
                n++;
            end
            total++;
            if (n >= 10) begin
                bad++; $display("FAIL ops_timeout[%0d]: got no out_valid in 10 cycles, required one", v);
            end else begin
                if (result !== tbl[v].e || illegal !== 1'b0) begin
                    bad++;
                    $display("FAIL ops_result[%0d]: got %h ill=%b, required %h ill=0", v, result, illegal, tbl[v].e);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_random();
        int n;
        for (int c = 0; c < 80; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = 3'($urandom_range(0, 7));
            ra        = {$urandom(), $urandom(), $urandom(), $urandom()};
            cnt       = 7'($urandom_range(0, 127));
            tag_in    = 7'($urandom_range(0, 127));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL rand_drain: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a_t [8];
        logic [6:0]   c_t [8];
        logic [2:0]   o_t [8];
        logic         exp_rdy, acc, held;
        logic [135:0] held_val;
        int           idx, c;
        for (int k = 0; k < 8; k++) begin
            a_t[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
            c_t[k] = 7'(k * 9 + 1);
            o_t[k] = 3'(k % 5);
        end
        idx = 0; c = 0; held = 1'b0; held_val = '0;
        while ((idx < 8 || sb.size() != 0) && c < 40) begin
            in_valid = (idx < 8);
            if (idx < 8) begin
                op = o_t[idx]; ra = a_t[idx]; cnt = c_t[idx]; tag_in = 7'(idx + 64);
            end
            out_ready = !(c >= 2 && c < 5);
            #3;
            exp_rdy = !(sb.size() == STAGES && !out_ready);
            if (in_valid) begin
                total++;
                if (in_ready !== exp_rdy) begin
                    bad++; $display("FAIL b2b_in_ready[c%0d]: got %b, required %b", c, in_ready, exp_rdy);
                end
            end
            if (out_valid && !out_ready) begin
                if (held) begin
                    total++;
                    if ({result, tag_out, illegal} !== held_val) begin
                        bad++; $display("FAIL b2b_stall_hold[c%0d]: got %h, required %h", c, {result, tag_out, illegal}, held_val);
                    end
                end
                held_val = {result, tag_out, illegal};
                held = 1'b1;
            end else begin
                held = 1'b0;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            c++;
        end
        in_valid = 1'b0;
        total++;
        if (idx != 8 || sb.size() != 0) begin
            bad++; $display("FAIL b2b_complete: got issued=%0d pending=%0d, required 8 and 0", idx, sb.size());
        end
    endtask

    task automatic test_flush_reset();
        int n;
        // Two ops in flight, then flush with a third op offered.
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd0; ra = SEQ; cnt = 7'd1; tag_in = 7'd1;
        @(posedge clk); #1;
        op = 3'd2; cnt = 7'd2; tag_in = 7'd2;
        @(posedge clk); #1;
        flush = 1'b1; op = 3'd3; tag_in = 7'd3;
        #3;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b, required 0", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #3;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid: got %b, required 0", out_valid); end
        // A normal op after the flush.
        @(posedge clk); #1;
        in_valid = 1'b1; op = 3'd1; ra = SEQ; cnt = 7'd4; tag_in = 7'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (n < 10) begin
            #3;
            if (out_valid) break;
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n >= 10 || tag_out !== 7'd9 || result !== 128'h00102030405060708090A0B0C0D0E0F0) begin
            bad++; $display("FAIL flush_after_op: got tag=%h result=%h waited=%0d, required tag=09 result=00102030405060708090a0b0c0d0e0f0", tag_out, result, n);
        end
        @(posedge clk); #1;
        // Reset mid-stream with ops in flight.
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd4; cnt = 7'd5; tag_in = 7'd11;
        @(posedge clk); #1;
        tag_in = 7'd12;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1; op = 3'd0; ra = SEQ; cnt = 7'd3; tag_in = 7'd13;
        #3;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid: got %b, required 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready: got %b, required 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (n < 10) begin
            #3;
            if (out_valid) break;
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n >= 10 || result !== EXP27 || tag_out !== 7'd13) begin
            bad++; $display("FAIL rstmid_op: got result=%h tag=%h waited=%0d, required %h tag=0d", result, tag_out, n, EXP27);
        end
        @(posedge clk); #1;
        // Reserved opcode.
        in_valid = 1'b1; op = 3'b110; ra = SEQ; cnt = 7'd5; tag_in = 7'd14;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (n < 10) begin
            #3;
            if (out_valid) break;
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n >= 10 || illegal !== 1'b1 || result !== '0) begin
            bad++; $display("FAIL illegal_op: got ill=%b result=%h waited=%0d, required ill=1 result=0", illegal, result, n);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_ops();
        test_random();
        test_back_to_back();
        test_flush_reset();
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by time 100000, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
